// File: rtl/cdc_pkg.sv
//------------------------------------------------------------------------------
// Module : cdc_pkg
// Brief  : Shared types and constants for the toggle req/ack CDC blocks.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package cdc_pkg;

  localparam int SYNC_STAGES_MIN    = 2;
  localparam int DATA_WIDTH_DEFAULT = 8;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_e;

endpackage

`default_nettype wire

// File: rtl/ack_sync_chain.sv
//------------------------------------------------------------------------------
// Module : ack_sync_chain
// Brief  : Multi-flop single-bit synchronizer with synchronous reset.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ack_sync_chain
  import cdc_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic sync_out
);

  // Depths below the metastability-safe minimum are raised to it.
  localparam int DEPTH = (STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : STAGES;

  logic [DEPTH-1:0] sync_q;
  logic [DEPTH-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[DEPTH-2:0], async_in};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign sync_out = sync_q[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/cdc_handshake_sender.sv
//------------------------------------------------------------------------------
// Module : cdc_handshake_sender
// Brief  : Source end of a toggle req/ack CDC; holds one word per transfer.
//          Optional WAIT_ACK timeout flag enabled by CDC_SENDER_TIMEOUT_EN.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cdc_handshake_sender
  import cdc_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEFAULT,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  xfer_req,
  output logic [DATA_WIDTH-1:0] xfer_data,
  input  logic                  xfer_ack_async,
  output logic                  busy
`ifdef CDC_SENDER_TIMEOUT_EN
  ,
  output logic                  timeout_err
`endif
);

  state_e                state_q, state_d;
  logic                  req_q, req_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  ack_s;
  logic                  accept;

  ack_sync_chain #(
    .STAGES   (SYNC_STAGES)
  ) u_ack_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (xfer_ack_async),
    .sync_out (ack_s)
  );

  // Ready comes from state only, so upstream valid cannot loop back into it.
  assign in_ready = (state_q == IDLE) && !reset;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          data_d  = in_data;
          req_d   = ~req_q;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (ack_s == req_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      data_q  <= data_d;
    end
  end

  assign xfer_req  = req_q;
  assign xfer_data = data_q;
  assign busy      = (state_q == WAIT_ACK);

`ifdef CDC_SENDER_TIMEOUT_EN
  localparam int                CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // Counter saturates at the limit; the error flag is sticky until reset.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (accept) begin
      cnt_d = '0;
    end else if (state_q == WAIT_ACK) begin
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      if (cnt_d == CNT_MAX) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign timeout_err = err_q;
`else
  // Timeout limit has no effect in this build; fold it into a sink net.
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = (TIMEOUT_CYCLES > 0);
`endif

endmodule

`default_nettype wire

// File: tb/tb_cdc_handshake_sender.sv
//------------------------------------------------------------------------------
// Module : tb_cdc_handshake_sender
// Brief  : Directed self-checking bench for cdc_handshake_sender.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_cdc_handshake_sender;

  localparam int DW = 8;
  localparam int SS = 2;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          xfer_req;
  logic [DW-1:0] xfer_data;
  logic          xfer_ack_async = 1'b0;
  logic          busy;
`ifdef CDC_SENDER_TIMEOUT_EN
  logic          timeout_err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cdc_handshake_sender #(
    .DATA_WIDTH     (DW),
    .SYNC_STAGES    (SS),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .xfer_req       (xfer_req),
    .xfer_data      (xfer_data),
    .xfer_ack_async (xfer_ack_async),
    .busy           (busy)
`ifdef CDC_SENDER_TIMEOUT_EN
    ,
    .timeout_err    (timeout_err)
`endif
  );

  typedef struct {
    logic          rst;
    logic          vld;
    logic [DW-1:0] din;
    logic          ack;
    logic          rdy;
    logic          req;
    logic [DW-1:0] dat;
    logic          bsy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic vld, input logic [DW-1:0] din,
                     input logic ack, input logic rdy, input logic req,
                     input logic [DW-1:0] dat, input logic bsy);
    vec_t v;
    v.rst = rst; v.vld = vld; v.din = din; v.ack = ack;
    v.rdy = rdy; v.req = req; v.dat = dat; v.bsy = bsy;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cyc;

    //   rst vld din    ack | rdy req dat    bsy
    add(1, 0, 8'h00, 0,    0,  0, 8'h00, 0);  // reset held 3 cycles
    add(1, 0, 8'h00, 0,    0,  0, 8'h00, 0);
    add(1, 0, 8'h00, 0,    0,  0, 8'h00, 0);
    add(0, 0, 8'h00, 0,    1,  0, 8'h00, 0);  // released: idle defaults
    add(0, 1, 8'hA5, 0,    0,  1, 8'hA5, 1);  // accept A5
    add(0, 1, 8'h3C, 1,    0,  1, 8'hA5, 1);  // ack driven, 3C held off
    add(0, 1, 8'h3C, 1,    0,  1, 8'hA5, 1);
    add(0, 1, 8'h3C, 1,    1,  1, 8'hA5, 0);  // SS+1 edges after ack: idle
    add(0, 1, 8'h3C, 1,    0,  0, 8'h3C, 1);  // 3C accepted, req toggles
    add(0, 0, 8'h00, 1,    0,  0, 8'h3C, 1);
    add(0, 0, 8'h00, 0,    0,  0, 8'h3C, 1);
    add(0, 0, 8'h00, 0,    0,  0, 8'h3C, 1);
    add(0, 0, 8'h00, 0,    1,  0, 8'h3C, 0);
    add(0, 1, 8'h77, 0,    0,  1, 8'h77, 1);  // accept 77
    add(1, 0, 8'h00, 0,    0,  0, 8'h00, 0);  // reset mid-transfer
    add(0, 0, 8'h00, 1,    1,  0, 8'h00, 0);  // ack toggles alone while idle
    add(0, 0, 8'h00, 1,    1,  0, 8'h00, 0);
    add(0, 0, 8'h00, 1,    1,  0, 8'h00, 0);
    add(0, 0, 8'h00, 0,    1,  0, 8'h00, 0);  // spurious toggle back
    add(0, 0, 8'h00, 0,    1,  0, 8'h00, 0);
    add(0, 0, 8'h00, 0,    1,  0, 8'h00, 0);
    add(0, 1, 8'h11, 0,    0,  1, 8'h11, 1);  // accept 11, ack_s=0 != req
    add(0, 0, 8'h00, 0,    0,  1, 8'h11, 1);
    add(0, 0, 8'h00, 0,    0,  1, 8'h11, 1);
    add(0, 0, 8'h00, 1,    0,  1, 8'h11, 1);
    add(0, 0, 8'h00, 1,    0,  1, 8'h11, 1);
    add(0, 0, 8'h00, 1,    1,  1, 8'h11, 0);  // matched: idle

    // Reset-phase readiness is combinational, check before the first edge.
    #1;
    chk("rdy_in_reset", 32'(in_ready), 32'd0);

    foreach (vecs[i]) begin
      reset          = vecs[i].rst;
      in_valid       = vecs[i].vld;
      in_data        = vecs[i].din;
      xfer_ack_async = vecs[i].ack;
      step();
      chk($sformatf("v%0d_ready", i), 32'(in_ready),  32'(vecs[i].rdy));
      chk($sformatf("v%0d_req", i),   32'(xfer_req),  32'(vecs[i].req));
      chk($sformatf("v%0d_data", i),  32'(xfer_data), 32'(vecs[i].dat));
      chk($sformatf("v%0d_busy", i),  32'(busy),      32'(vecs[i].bsy));
    end

    // Round-trip latency: ack toggle to in_ready takes SS+1 edges.
    in_valid = 1'b1;
    in_data  = 8'h5A;
    step();
    in_valid = 1'b0;
    chk("seq_req", 32'(xfer_req), 32'd0);
    chk("seq_data", 32'(xfer_data), 32'h5A);
    xfer_ack_async = 1'b0;
    cyc = 0;
    while (!in_ready && cyc < 20) begin
      step();
      cyc++;
    end
    chk("seq_latency", 32'(cyc), 32'(SS + 1));
    chk("seq_data_hold", 32'(xfer_data), 32'h5A);

`ifdef CDC_SENDER_TIMEOUT_EN
    reset = 1'b1;
    xfer_ack_async = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();
    chk("to_reset", 32'(timeout_err), 32'd0);
    in_valid = 1'b1;
    in_data  = 8'hC3;
    step();
    in_valid = 1'b0;
    for (int k = 1; k <= TO; k++) begin
      step();
      if (k == TO - 1) chk("to_before", 32'(timeout_err), 32'd0);
    end
    chk("to_set", 32'(timeout_err), 32'd1);
    chk("to_busy", 32'(busy), 32'd1);
    step();
    step();
    chk("to_sticky", 32'(timeout_err), 32'd1);
    xfer_ack_async = 1'b1;
    cyc = 0;
    while (!in_ready && cyc < 20) begin
      step();
      cyc++;
    end
    chk("to_done_latency", 32'(cyc), 32'(SS + 1));
    chk("to_after_done", 32'(timeout_err), 32'd1);
    chk("to_idle", 32'(busy), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
